// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
//
// Purpose:
//   EX/MEM pipeline boundary built as a 2-entry elastic buffer. Each entry
//   carries the ALU result, the store data, the destination register, the
//   MEM/WB control bits, and a branch decision that is resolved when the
//   entry is captured. The head entry is presented to the MEM stage through a
//   valid/ready handshake. in_ready_o depends only on occupancy, so the
//   upstream stage never sees a combinational path from out_ready_i.
//
// Configuration:
//   EX_MEM_BNE_EN - when defined, branch_ne_i selects BNE semantics
//                   (taken = branch_i && !zero_i). When undefined, branch_ne_i
//                   is ignored and taken = branch_i && zero_i.
//
// Ports:
//   clk_i            in   1   clock (rising edge)
//   rst_i            in   1   asynchronous active-low reset
//   in_valid_i       in   1   EX-stage entry valid
//   in_ready_o       out  1   buffer can accept (count < 2)
//   alu_result_i     in  32   ALU result
//   zero_i           in   1   ALU zero flag
//   rt_data_i        in  32   store data
//   write_reg_i      in   5   destination register
//   reg_write_i      in   1   register write enable
//   mem_read_i       in   1   memory read
//   mem_write_i      in   1   memory write
//   branch_i         in   1   branch instruction
//   branch_ne_i      in   1   BNE select (only used with EX_MEM_BNE_EN)
//   pc_branch_i      in  32   branch target
//   flush_i          in   1   discard all held entries (wins over push/pop)
//   out_valid_o      out  1   head entry valid
//   out_ready_i      in   1   MEM stage consumes the head
//   result_o         out 32   head ALU result
//   wdata_o          out 32   head store data
//   write_reg_o      out  5   head destination register
//   reg_write_o      out  1   head register write enable
//   mem_read_o       out  1   head memory read
//   mem_write_o      out  1   head memory write
//   pc_src_o         out  1   head is a taken branch
//   branch_target_o  out 32   head branch target
// ----------------------------------------------------------------------------
module ex_mem_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] alu_result_i,
    input  logic        zero_i,
    input  logic [31:0] rt_data_i,
    input  logic [4:0]  write_reg_i,
    input  logic        reg_write_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        branch_i,
    input  logic        branch_ne_i,
    input  logic [31:0] pc_branch_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic [31:0] wdata_o,
    output logic [4:0]  write_reg_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        pc_src_o,
    output logic [31:0] branch_target_o
);

    localparam int DEPTH = 2;

    // One buffered EX/MEM record.
    typedef struct packed {
        logic [31:0] result;
        logic [31:0] wdata;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       wr_ptr_reg;
    logic       wr_ptr_next;
    logic       rd_ptr_reg;
    logic       rd_ptr_next;
    entry_t     mem_reg [DEPTH];

    entry_t     in_entry;
    entry_t     head_entry;
    logic       taken;
    logic       push;
    logic       pop;
    logic       write_en;

    // ------------------------------------------------------------------
    // Branch resolution at capture time
    // ------------------------------------------------------------------
`ifdef EX_MEM_BNE_EN
    assign taken = branch_i && (branch_ne_i ? !zero_i : zero_i);
`else
    // branch_ne_i has no function in this build; tie it off explicitly.
    logic unused_bne;
    assign unused_bne = branch_ne_i;
    assign taken      = branch_i && zero_i;
`endif

    always_comb begin
        in_entry           = '0;
        in_entry.result    = alu_result_i;
        in_entry.wdata     = rt_data_i;
        in_entry.write_reg = write_reg_i;
        in_entry.reg_write = reg_write_i;
        in_entry.mem_read  = mem_read_i;
        in_entry.mem_write = mem_write_i;
        in_entry.taken     = taken;
        in_entry.target    = pc_branch_i;
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Ready is a pure function of occupancy; during reset count_reg is 0,
    // so in_ready_o is held high and out_valid_o low.
    assign in_ready_o  = (count_reg < 2'd2);
    assign out_valid_o = (count_reg != 2'd0);

    assign push = in_valid_i && in_ready_o;
    assign pop  = out_valid_o && out_ready_i;

    // Storage is only written on an accepted push that is not flushed.
    assign write_en = push && !flush_i;

    // ------------------------------------------------------------------
    // Occupancy and pointer update
    // ------------------------------------------------------------------
    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush_i) begin
            // Flush dominates: concurrent push dropped, concurrent pop ignored.
            count_next  = 2'd0;
            wr_ptr_next = 1'b0;
            rd_ptr_next = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            unique case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage: one register slot per pointer value. Slots are
    // cleared on reset so nothing from an interrupted stream survives.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    mem_reg[gi] <= '0;
                end else if (write_en && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= in_entry;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Head outputs: selected straight from the storage registers and
    // forced to zero when the buffer is empty. No input reaches these
    // outputs without passing through a flop.
    // ------------------------------------------------------------------
    always_comb begin
        head_entry = '0;
        if (out_valid_o) begin
            head_entry = mem_reg[rd_ptr_reg];
        end
    end

    assign result_o        = head_entry.result;
    assign wdata_o         = head_entry.wdata;
    assign write_reg_o     = head_entry.write_reg;
    assign reg_write_o     = head_entry.reg_write;
    assign mem_read_o      = head_entry.mem_read;
    assign mem_write_o     = head_entry.mem_write;
    assign pc_src_o        = out_valid_o && head_entry.taken;
    assign branch_target_o = head_entry.target;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage
//
// Directed bench for ex_mem_stage. Inputs change on the falling edge; each
// tick() first compares the DUT outputs against a reference queue, then
// applies the accepted push/pop/flush to the queue, then advances one clock.
// ----------------------------------------------------------------------------
module tb_ex_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] alu_result_i;
    logic        zero_i;
    logic [31:0] rt_data_i;
    logic [4:0]  write_reg_i;
    logic        reg_write_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        branch_i;
    logic        branch_ne_i;
    logic [31:0] pc_branch_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic [31:0] wdata_o;
    logic [4:0]  write_reg_o;
    logic        reg_write_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        pc_src_o;
    logic [31:0] branch_target_o;

    always #5 clk_i = ~clk_i;

    ex_mem_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .alu_result_i    (alu_result_i),
        .zero_i          (zero_i),
        .rt_data_i       (rt_data_i),
        .write_reg_i     (write_reg_i),
        .reg_write_i     (reg_write_i),
        .mem_read_i      (mem_read_i),
        .mem_write_i     (mem_write_i),
        .branch_i        (branch_i),
        .branch_ne_i     (branch_ne_i),
        .pc_branch_i     (pc_branch_i),
        .flush_i         (flush_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .result_o        (result_o),
        .wdata_o         (wdata_o),
        .write_reg_o     (write_reg_o),
        .reg_write_o     (reg_write_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .pc_src_o        (pc_src_o),
        .branch_target_o (branch_target_o)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        pc;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] res, input logic [31:0] wd,
                          input logic [4:0] wr, input logic rw, input logic mr, input logic mw,
                          input logic br, input logic z, input logic bne, input logic [31:0] tgt);
        in_valid_i   = v;
        alu_result_i = res;
        rt_data_i    = wd;
        write_reg_i  = wr;
        reg_write_i  = rw;
        mem_read_i   = mr;
        mem_write_i  = mw;
        branch_i     = br;
        zero_i       = z;
        branch_ne_i  = bne;
        pc_branch_i  = tgt;
    endtask

    function automatic logic model_taken();
`ifdef EX_MEM_BNE_EN
        return branch_i && (branch_ne_i ? !zero_i : zero_i);
`else
        return branch_i && zero_i;
`endif
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, ".valid"},  out_valid_o, 0);
        check({tag, ".ready"},  in_ready_o, 1);
        check({tag, ".result"}, result_o, 0);
        check({tag, ".wdata"},  wdata_o, 0);
        check({tag, ".wreg"},   write_reg_o, 0);
        check({tag, ".ctl"},    {reg_write_o, mem_read_o, mem_write_o}, 0);
        check({tag, ".pcsrc"},  pc_src_o, 0);
        check({tag, ".target"}, branch_target_o, 0);
    endtask

    // Called just after a falling edge with inputs settled.
    task automatic tick(input string tag);
        int   sz;
        logic do_push;
        logic do_pop;
        exp_t e;
        sz = q.size();
        check({tag, ".in_ready"},  in_ready_o, sz < 2);
        check({tag, ".out_valid"}, out_valid_o, sz != 0);
        if (sz != 0) begin
            check({tag, ".result"}, result_o, q[0].res);
            check({tag, ".wdata"},  wdata_o, q[0].wd);
            check({tag, ".wreg"},   write_reg_o, q[0].wr);
            check({tag, ".ctl"},    {reg_write_o, mem_read_o, mem_write_o},
                                    {q[0].rw, q[0].mr, q[0].mw});
            check({tag, ".pcsrc"},  pc_src_o, q[0].pc);
            check({tag, ".target"}, branch_target_o, q[0].tgt);
        end else begin
            check({tag, ".empty_result"}, result_o, 0);
            check({tag, ".empty_pcsrc"},  pc_src_o, 0);
            check({tag, ".empty_target"}, branch_target_o, 0);
        end
        $display("tick %s: size=%0d in_v=%0d out_r=%0d flush=%0d result_o=%h",
                 tag, sz, in_valid_i, out_ready_i, flush_i, result_o);
        do_push = in_valid_i && (sz < 2);
        do_pop  = (sz != 0) && out_ready_i;
        if (flush_i) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.res = alu_result_i;
                e.wd  = rt_data_i;
                e.wr  = write_reg_i;
                e.rw  = reg_write_i;
                e.mr  = mem_read_i;
                e.mw  = mem_write_i;
                e.pc  = model_taken();
                e.tgt = pc_branch_i;
                q.push_back(e);
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_i       = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        idle();
        @(negedge clk_i);
        // Reset state
        check_zero_outputs("reset");
        @(negedge clk_i);
        rst_i = 1'b1;

        // Single pass
        out_ready_i = 1'b1;
        set_in(1, 32'h10, 32'hAAAA_0001, 5'd8, 1, 0, 0, 0, 0, 0, 32'h0);
        tick("single_push");
        idle();
        tick("single_out");
        tick("single_empty");

        // Backpressure / full, third push refused
        out_ready_i = 1'b0;
        set_in(1, 32'h11, 32'h0000_1111, 5'd1, 1, 1, 0, 0, 0, 0, 32'h0);
        tick("bp_push_a");
        set_in(1, 32'h22, 32'h0000_2222, 5'd2, 0, 0, 1, 0, 0, 0, 32'h0);
        tick("bp_push_b");
        set_in(1, 32'h33, 32'h0000_3333, 5'd3, 1, 0, 0, 0, 0, 0, 32'h0);
        tick("bp_push_c_refused");
        tick("bp_hold");
        idle();
        out_ready_i = 1'b1;
        tick("bp_pop_a");
        tick("bp_pop_b");
        tick("bp_empty");

        // Simultaneous push/pop at count=1
        out_ready_i = 1'b0;
        set_in(1, 32'h44, 32'h0, 5'd4, 1, 0, 0, 0, 0, 0, 32'h0);
        tick("sim_push_x");
        out_ready_i = 1'b1;
        set_in(1, 32'h55, 32'h0, 5'd5, 1, 0, 0, 0, 0, 0, 32'h0);
        tick("sim_pushpop");
        set_in(1, 32'h66, 32'h0, 5'd6, 1, 0, 0, 0, 0, 0, 32'h0);
        tick("sim_pushpop2");
        idle();
        tick("sim_drain");
        tick("sim_empty");

        // Branch resolution
        out_ready_i = 1'b0;
        set_in(1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 1, 0, 32'h40);
        tick("br_taken_push");
        set_in(1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0, 0, 32'h80);
        tick("br_not_taken_push");
        idle();
        out_ready_i = 1'b1;
        tick("br_taken_head");
        tick("br_not_taken_head");
        // BNE select: taken only when the macro is enabled
        set_in(1, 32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 0, 1, 32'hC0);
        tick("bne_push");
        idle();
        tick("bne_head");
        tick("bne_empty");

        // Flush at count=2 with a concurrent push
        out_ready_i = 1'b0;
        set_in(1, 32'h77, 32'h0, 5'd7, 1, 0, 0, 0, 0, 0, 32'h0);
        tick("fl_push1");
        set_in(1, 32'h88, 32'h0, 5'd9, 1, 0, 0, 0, 0, 0, 32'h0);
        tick("fl_push2");
        set_in(1, 32'h99, 32'h0, 5'd10, 1, 0, 0, 0, 0, 0, 32'h0);
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        tick("fl_flush");
        flush_i = 1'b0;
        idle();
        tick("fl_after");

        // Flush at count=1 with concurrent push and pop
        out_ready_i = 1'b0;
        set_in(1, 32'hAB, 32'h0, 5'd11, 1, 0, 0, 0, 0, 0, 32'h0);
        tick("fl1_push");
        out_ready_i = 1'b1;
        set_in(1, 32'hCD, 32'h0, 5'd12, 1, 0, 0, 0, 0, 0, 32'h0);
        flush_i = 1'b1;
        tick("fl1_flush");
        flush_i = 1'b0;
        idle();
        tick("fl1_after");

        // Asynchronous reset mid-stream at count=2
        out_ready_i = 1'b0;
        set_in(1, 32'h1234, 32'h0, 5'd13, 1, 0, 1, 1, 1, 0, 32'h100);
        tick("rst_push1");
        set_in(1, 32'h5678, 32'h0, 5'd14, 1, 1, 0, 0, 0, 0, 32'h0);
        tick("rst_push2");
        idle();
        #2;
        rst_i = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        q.delete();
        @(negedge clk_i);
        rst_i = 1'b1;
        tick("post_rst_empty");
        out_ready_i = 1'b1;
        set_in(1, 32'hBEEF, 32'h0, 5'd15, 1, 0, 0, 0, 0, 0, 32'h0);
        tick("post_rst_push");
        idle();
        tick("post_rst_out");
        tick("post_rst_empty2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk_i (posedge) and rst_i (active-low, asynchronous).
REQ-002 SHALL have these ports:
- clk_i  in  1  clock
- rst_i  in  1  async active-low reset
- in_valid_i  in  1  EX-stage entry valid
- in_ready_o  out  1  stage can accept
- alu_result_i  in  32  ALU result
- zero_i  in  1  ALU zero flag
- rt_data_i  in  32  store data
- write_reg_i  in  5  destination register
- reg_write_i, mem_read_i, mem_write_i, branch_i  in  1 each  control bits
- branch_ne_i  in  1  BNE select, ignored unless macro defined
- pc_branch_i  in  32  branch target
- flush_i  in  1  discard all held entries
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  MEM stage consumes head
- result_o, wdata_o  out  32 each  head ALU result, store data
- write_reg_o  out  5  head destination
- reg_write_o, mem_read_o, mem_write_o  out  1 each  head controls
- pc_src_o  out  1  head is a taken branch
- branch_target_o  out  32  head branch target

Function
REQ-003 SHALL buffer entries in a 2-deep FIFO with a 2-bit occupancy count from 0 to 2.
REQ-004 SHALL drive in_ready_o = (count < 2) combinationally, with no dependence on out_ready_i.
REQ-005 SHALL accept an entry on a rising edge when in_valid_i && in_ready_o, capturing all in-side fields.
REQ-006 SHALL pop the head on a rising edge when out_valid_o && out_ready_i.
REQ-007 SHALL, on a simultaneous push and pop, leave count unchanged and preserve order.
REQ-008 SHALL, when count=1 with push and pop in the same cycle, present the new entry at the head on the next cycle.
REQ-009 SHALL drive out_valid_o = (count != 0); all head outputs SHALL come directly from a register, with zero cycles of combinational path from the inputs.
REQ-010 SHALL resolve branches at capture time: taken = branch_i && zero_i. This taken bit is stored per entry and drives pc_src_o = out_valid_o && head.taken.
REQ-011 SHALL hold head outputs stable while out_valid_o=1 and out_ready_i=0.
REQ-012 SHALL drive all head outputs to zero when count=0.
REQ-013 SHALL, on flush_i=1, set count=0 on the next edge. Flush has priority: a concurrent push is dropped and a concurrent pop is ignored.
REQ-014 SHALL have a push-to-out_valid_o latency of 1 cycle from an empty FIFO.
REQ-015 SHALL use read and write pointers of 1 bit each that wrap modulo 2.

Reset
REQ-016 SHALL, while rst_i=0, asynchronously clear count, both pointers, and all stored entries.
REQ-017 SHALL hold out_valid_o=0, pc_src_o=0, and all other outputs at 0 while in reset, and SHALL hold in_ready_o=1.
REQ-018 SHALL discard any in-flight entries on reset assertion mid-operation, with no partial state retained.

Configuration
REQ-019 SHALL support the macro EX_MEM_BNE_EN.
- When defined: taken = branch_i && (branch_ne_i ? !zero_i : zero_i).
- When undefined: branch_ne_i is unconnected internally and taken = branch_i && zero_i.

Verification
REQ-020 SHALL pass these directed scenarios:
- Single pass: push result=0x0000_0010, write_reg=8, reg_write=1 with out_ready_i=1 -> out_valid_o=1 for one cycle, with result_o=0x10, write_reg_o=8, and count returning to 0.
- Backpressure/full: hold out_ready_i=0 and push A=0x11, B=0x22 -> in_ready_o=0 after the 2nd push and a 3rd push is not accepted; then out_ready_i=1 -> output order is 0x11 then 0x22.
- Simultaneous push/pop at count=1 -> count stays 1, and the head sequence is preserved with no loss or duplication.
- Branch: branch_i=1, zero_i=1, pc_branch=0x0000_0040 -> pc_src_o=1 and branch_target_o=0x40 at the head. With zero_i=0 -> pc_src_o=0. With EX_MEM_BNE_EN defined and branch_ne_i=1, zero_i=0 -> pc_src_o=1.
- Flush with count=2 plus a concurrent push -> next cycle count=0, out_valid_o=0, in_ready_o=1.
- Reset asserted asynchronously mid-stream with count=2 -> all outputs 0 immediately and in_ready_o=1; after release, the first push emerges after 1 cycle.
